// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - bi, borrow-out bo, one bit per clock LSB first.
// Start/ready handshake in, one-cycle done pulse out; d/bo hold until the next completion.
module serial_subtractor #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bi,
   input  logic         start,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] d,
   output logic         bo
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   ar_q, ar_d;
   logic [N-1:0]   br_q, br_d;
   logic [N-1:0]   r_q, r_d;
   logic           borrow_q, borrow_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   d_q, d_d;
   logic           bo_q, bo_d;

   logic           x, diff_bit, borrow_nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         ar_q     <= '0;
         br_q     <= '0;
         r_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         d_q      <= '0;
         bo_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ar_q     <= ar_d;
         br_q     <= br_d;
         r_q      <= r_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         d_q      <= d_d;
         bo_q     <= bo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ar_d       = ar_q;
      br_d       = br_q;
      r_d        = r_q;
      borrow_d   = borrow_q;
      cnt_d      = cnt_q;
      d_d        = d_q;
      bo_d       = bo_q;

      // One full-subtractor cell, reused every SHIFT cycle on the LSBs.
      x          = ar_q[0] ^ br_q[0];
      diff_bit   = x ^ borrow_q;
      borrow_nxt = (~ar_q[0] & br_q[0]) | (~x & borrow_q);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ar_d     = a;
               br_d     = b;
               borrow_d = bi;
               cnt_d    = '0;
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            ar_d         = ar_q >> 1;
            br_d         = br_q >> 1;
            r_d          = r_q >> 1;
            r_d[N-1]     = diff_bit;
            borrow_d     = borrow_nxt;
            cnt_d        = cnt_q + CW'(1);
            // Publish on the last bit so d/bo never show a partial result.
            if (cnt_q == CW'(N - 1)) begin
               d_d     = r_d;
               bo_d    = borrow_nxt;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready = (state_q != SHIFT);
   assign done  = (state_q == DONE);
   assign d     = d_q;
   assign bo    = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + exhaustive self-checking bench for serial_subtractor at N = 4.
module tb_serial_subtractor;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [N-1:0] a = '0, b = '0;
   logic         bi = 1'b0, start = 1'b0;
   logic         ready, done, bo;
   logic [N-1:0] d;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] last_d = '0;
   logic         last_bo = 1'b0;

   serial_subtractor #(.N(N)) dut (
      .clk(clk), .rstn(rstn), .a(a), .b(b), .bi(bi), .start(start),
      .ready(ready), .done(done), .d(d), .bo(bo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         bi;
      logic [N-1:0] ed;
      logic         ebo;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Accept one op, check busy/latency/result/hold; inputs are scrambled after accept.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tbi,
                         input logic [N-1:0] ed, input logic ebo, input string nm);
      int cyc;
      @(negedge clk);
      chk({nm, " ready_before"}, ready, 1);
      a = ta; b = tb_; bi = tbi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); bi = 1'($urandom);
      cyc = 0;
      while (!done && cyc < 20) begin
         chk({nm, " ready_busy"}, ready, 0);
         chk({nm, " d_hold_busy"}, d, last_d);
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, cyc, N);
      chk({nm, " d"}, d, ed);
      chk({nm, " bo"}, bo, ebo);
      last_d = ed; last_bo = ebo;
      @(negedge clk);
      chk({nm, " done_after"}, done, 0);
      chk({nm, " ready_after"}, ready, 1);
      chk({nm, " d_after"}, d, ed);
   endtask

   initial begin
      vec_t vt[7];
      int   ndone;
      vt[0] = '{4'd3,  4'd3,  1'b0, 4'd0,  1'b0};
      vt[1] = '{4'd3,  4'd7,  1'b0, 4'd12, 1'b1};
      vt[2] = '{4'd15, 4'd1,  1'b0, 4'd14, 1'b0};
      vt[3] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
      vt[4] = '{4'd8,  4'd8,  1'b1, 4'd15, 1'b1};
      vt[5] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
      vt[6] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst ready", ready, 1);
      chk("rst done", done, 0);
      chk("rst d", d, 0);
      chk("rst bo", bo, 0);
      rstn = 1'b1;

      // Table-driven directed vectors
      for (int i = 0; i < 7; i++)
         run_op(vt[i].a, vt[i].b, vt[i].bi, vt[i].ed, vt[i].ebo, $sformatf("vec%0d", i));

      // Busy/hold: start pulsed mid-operation must be ignored
      @(negedge clk);
      a = 4'd7; b = 4'd3; bi = 1'b0; start = 1'b1;
      ndone = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         start = (j == 1);
         a = (j == 1) ? 4'd15 : N'($urandom);
         b = (j == 1) ? 4'd15 : N'($urandom);
         chk("busy ready", ready, 0);
         chk("busy done", done, 0);
         chk("busy d_hold", d, last_d);
      end
      @(negedge clk);
      a = N'($urandom); b = N'($urandom);
      chk("busy done_pulse", done, 1);
      chk("busy d", d, 4);
      chk("busy bo", bo, 0);
      last_d = 4'd4; last_bo = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         a = N'($urandom); b = N'($urandom);
         if (done) ndone++;
      end
      chk("busy no_second_op", ndone, 0);
      chk("busy ready_idle", ready, 1);
      chk("busy d_final", d, 4);

      // Back-to-back with start held high
      @(negedge clk);
      a = 4'd9; b = 4'd2; bi = 1'b0; start = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk($sformatf("b2b done j%0d", j), done, (j == 4 || j == 9));
         chk($sformatf("b2b ready j%0d", j), ready, (j == 4 || j == 9));
         if (j == 4) begin
            chk("b2b d1", d, 7);
            chk("b2b bo1", bo, 0);
         end
         if (j == 9) begin
            chk("b2b d2", d, 9);
            chk("b2b bo2", bo, 1);
            start = 1'b0;
         end
         if (j == 0) begin
            a = 4'd2; b = 4'd9;
         end
      end
      last_d = 4'd9; last_bo = 1'b1;
      @(negedge clk);
      chk("b2b idle done", done, 0);
      chk("b2b idle ready", ready, 1);

      // Reset mid-operation
      @(negedge clk);
      a = 4'd5; b = 4'd1; bi = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst ready", ready, 1);
      chk("midrst done", done, 0);
      chk("midrst d", d, 0);
      chk("midrst bo", bo, 0);
      @(negedge clk);
      rstn = 1'b1;
      last_d = '0; last_bo = 1'b0;
      ndone = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midrst no_done", ndone, 0);
      run_op(4'd5, 4'd1, 1'b0, 4'd4, 1'b0, "post_rst");

      // Exhaustive against {bo, d} = {0, a} - b - bi
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               logic [N:0] ref5;
               ref5 = {1'b0, 4'(ia)} - 5'(ib) - 5'(ic);
               run_op(4'(ia), 4'(ib), 1'(ic), ref5[N-1:0], ref5[N],
                      $sformatf("ex a%0d b%0d bi%0d", ia, ib, ic));
            end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
